// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
//   RESET_PC_DEFAULT : fetch address used after reset unless overridden
//   IFU_DEPTH        : default prefetch buffer depth / outstanding request limit
//   NOP_INSTR        : instruction word presented when nothing valid is held
//   ifu_entry_t      : one prefetch buffer entry, {pc, instr}
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IFU_DEPTH        = 2;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifu_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO used for the prefetch buffer and the in-flight PC queue.
//   clk, reset : clock and synchronous active-high reset
//   flush_i    : empties the FIFO on this edge; overrides push and pop
//   push_i     : write wdata_i (ignored when full unless a pop happens too)
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch prefetch unit. Issues sequential word fetches to an
// in-order instruction memory, buffers returned words with their PCs and
// presents the oldest one to the IF/ID register. Redirects flush the buffer
// and discard responses to requests issued before the redirect.
//   clk, reset                      : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : fetch request handshake
//   imem_resp_valid/data            : in-order fetch responses
//   stall                           : decode holds the presented instruction
//   redirect_valid/redirect_pc      : new fetch stream (low two bits ignored)
//   instrF/pcF/pcPlus4F/validF      : buffer head presented to decode
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = IFU_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        validF
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fpc_q, fpc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] pcq_count, buf_count;
    logic             pcq_full, pcq_empty, buf_full, buf_empty;
    logic [31:0]      pcq_head;
    ifu_entry_t       buf_wdata, buf_head;

    logic [SUM_W-1:0] outstanding, occupancy, inflight_after;
    logic             credit_ok, dropping, resp_fire, req_fire;
    logic             pcq_pop, buf_push, buf_pop, valid_head;

    // Outstanding requests are the live ones in the PC queue plus the stale
    // ones still to be discarded; both consume credit until answered.
    assign outstanding = SUM_W'(pcq_count) + SUM_W'(drop_cnt_q);
    assign occupancy   = outstanding + SUM_W'(buf_count);
    assign credit_ok   = (occupancy < SUM_W'(DEPTH));

    // Credit only depends on registered counts, and a push always retires an
    // outstanding request, so a raised request cannot lose its credit.
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fpc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dropping  = (drop_cnt_q != '0);
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign pcq_pop   = resp_fire && !dropping;
    assign buf_push  = pcq_pop && !redirect_valid;

    assign valid_head = !reset && !buf_empty;
    assign buf_pop    = valid_head && !stall && !redirect_valid;

    assign buf_wdata.pc    = pcq_head;
    assign buf_wdata.instr = imem_resp_data;

    // Requests still owed a response after this edge; on a redirect every
    // one of them becomes stale.
    assign inflight_after = outstanding - SUM_W'(resp_fire) + SUM_W'(req_fire);

    always_comb begin
        fpc_d      = fpc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fpc_d      = align_word(redirect_pc);
            drop_cnt_d = CNT_W'(inflight_after);
        end else begin
            if (req_fire) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (resp_fire && dropping) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ifu_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .wdata_i (fpc_q),
        .pop_i   (pcq_pop),
        .rdata_o (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    ifu_fifo #(
        .WIDTH ($bits(ifu_entry_t)),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (buf_push),
        .wdata_i (buf_wdata),
        .pop_i   (buf_pop),
        .rdata_o (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    assign validF   = valid_head;
    assign instrF   = valid_head ? buf_head.instr : NOP_INSTR;
    assign pcF      = valid_head ? buf_head.pc : 32'h0;
    assign pcPlus4F = valid_head ? (buf_head.pc + 32'd4) : 32'h0;

    a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (outstanding != '0))
        else $error("ifu_prefetch: response with no outstanding request");

    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> !pcq_full);

    a_pcq_has_pc: assert property (@(posedge clk) disable iff (reset)
        pcq_pop |-> !pcq_empty);

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
        buf_push |-> (!buf_full || buf_pop));

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcPlus4F;
    logic        validF;

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instrF          (instrF),
        .pcF             (pcF),
        .pcPlus4F        (pcPlus4F),
        .validF          (validF)
    );

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;

    int ready_pct = 100;
    int lat_max   = 0;

    // Reference model: the program seen by decode is the straight-line word
    // stream starting at the last reset/redirect target.
    logic [31:0] exp_q[$];
    logic [31:0] push_pc;
    logic [31:0] fa_exp;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(push_pc);
            push_pc = push_pc + 32'd4;
        end
    endtask

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        push_pc = {pc[31:2], 2'b00};
        fa_exp  = push_pc;
        top_up();
    endtask

    task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) start_stream(rpc);
        top_up();
    endtask

    task automatic rand_cycle(input int stall_1_in, input int redir_1_in);
        logic        st, rv;
        logic [31:0] r, rpc;
        st = ($urandom_range(1, stall_1_in) == 1);
        rv = ($urandom_range(1, redir_1_in) == 1);
        r  = $urandom;
        if (r[2:0] == 3'd0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else                rpc = $urandom;
        cycle(st, rv, rpc);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        start_stream(RESET_PC);
        repeat (n - 1) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // In-order instruction memory, reset together with the DUT.
    initial begin
        logic [31:0] mq_addr[$];
        int          mq_due[$];
        int          cyc;
        logic        acc, srv, rst_s;
        logic [31:0] acc_addr;
        cyc             = 0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            rst_s    = reset;
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            srv      = imem_resp_valid;
            @(posedge clk);
            #2;
            cyc++;
            if (rst_s) begin
                mq_addr.delete();
                mq_due.delete();
            end else begin
                if (srv) begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
                if (acc) begin
                    mq_addr.push_back(acc_addr);
                    mq_due.push_back(cyc + int'($urandom_range(0, lat_max)));
                end
            end
            imem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(mq_addr[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic        prev_pend, prev_rst, prev_hold;
        logic [31:0] prev_addr, hold_pc, hold_instr, e, e4;
        int          stall_run, nready_run;
        prev_pend  = 1'b0;
        prev_rst   = 1'b1;
        prev_hold  = 1'b0;
        prev_addr  = '0;
        hold_pc    = '0;
        hold_instr = '0;
        stall_run  = 0;
        nready_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                checks++;
                if (imem_req_valid !== 1'b0 || validF !== 1'b0 || instrF !== 32'h0 ||
                    pcF !== 32'h0 || pcPlus4F !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_state: req_valid=%0b validF=%0b instrF=%h pcF=%h pcPlus4F=%h, required all zero",
                             imem_req_valid, validF, instrF, pcF, pcPlus4F);
                end
                prev_pend  = 1'b0;
                prev_hold  = 1'b0;
                prev_rst   = 1'b1;
                stall_run  = 0;
                nready_run = 0;
                continue;
            end

            if (prev_rst) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
                    errors++;
                    $display("FAIL first_request: valid=%0b addr=%h, required valid=1 addr=%h",
                             imem_req_valid, imem_req_addr, RESET_PC);
                end
            end
            prev_rst = 1'b0;

            if (prev_pend && !redirect_valid) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL req_hold: valid=%0b addr=%h, required valid=1 addr=%h",
                             imem_req_valid, imem_req_addr, prev_addr);
                end
            end

            if (redirect_valid) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_withdraw: req_valid=%0b, required 0", imem_req_valid);
                end
            end

            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_req_addr !== fa_exp) begin
                    errors++;
                    $display("FAIL fetch_addr: addr=%h, required %h", imem_req_addr, fa_exp);
                end
                fa_exp = fa_exp + 32'd4;
            end
            prev_pend = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;

            if (prev_hold) begin
                checks++;
                if (validF !== 1'b1 || pcF !== hold_pc || instrF !== hold_instr) begin
                    errors++;
                    $display("FAIL stall_freeze: validF=%0b pcF=%h instrF=%h, required 1 %h %h",
                             validF, pcF, instrF, hold_pc, hold_instr);
                end
            end
            prev_hold  = validF && stall && !redirect_valid;
            hold_pc    = pcF;
            hold_instr = instrF;

            stall_run = (stall && imem_req_ready && !redirect_valid) ? stall_run + 1 : 0;
            if (stall_run >= 10) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_credit: req_valid=%0b after %0d stalled cycles, required 0",
                             imem_req_valid, stall_run);
                end
            end

            nready_run = (!imem_req_ready && !stall && !redirect_valid) ? nready_run + 1 : 0;
            if (nready_run >= 8) begin
                checks++;
                if (validF !== 1'b0 || instrF !== 32'h0) begin
                    errors++;
                    $display("FAIL drain_nop: validF=%0b instrF=%h, required 0 00000000", validF, instrF);
                end
            end

            if (!validF) begin
                checks++;
                if (instrF !== 32'h0 || pcF !== 32'h0 || pcPlus4F !== 32'h0) begin
                    errors++;
                    $display("FAIL nop_outputs: instrF=%h pcF=%h pcPlus4F=%h, required all zero",
                             instrF, pcF, pcPlus4F);
                end
            end

            if (validF && !stall && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL consume: pcF=%h with no expected entry queued", pcF);
                end else begin
                    e  = exp_q.pop_front();
                    e4 = e + 32'd4;
                    if (pcF !== e || instrF !== instr_of(e) || pcPlus4F !== e4) begin
                        errors++;
                        $display("FAIL consume: pcF=%h instrF=%h pcPlus4F=%h, required %h %h %h",
                                 pcF, instrF, pcPlus4F, e, instr_of(e), e4);
                    end
                end
                consumed++;
            end
        end
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        start_stream(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // steady streaming from reset, 1-cycle memory
        repeat (20) cycle(1'b0, 1'b0, 32'h0);

        // long stall with the buffer filling up, then release
        repeat (12) cycle(1'b1, 1'b0, 32'h0);
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // redirect to an unaligned target with requests in flight
        lat_max = 2;
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_3103);
        repeat (15) cycle(1'b0, 1'b0, 32'h0);
        lat_max = 0;

        // memory not ready: short and long windows
        ready_pct = 0;
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        ready_pct = 100;
        repeat (8) cycle(1'b0, 1'b0, 32'h0);
        ready_pct = 0;
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        ready_pct = 100;
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // redirect together with stall, then a second redirect during the drop window
        lat_max = 1;
        repeat (2) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_5000);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_4000);
        repeat (20) cycle(1'b0, 1'b0, 32'h0);
        lat_max = 0;

        // address wrap at the top of the space
        cycle(1'b0, 1'b1, 32'hFFFF_FFF4);
        repeat (20) cycle(1'b0, 1'b0, 32'h0);

        // randomized traffic
        lat_max   = 2;
        ready_pct = 70;
        repeat (1500) rand_cycle(4, 25);

        // reset in the middle of traffic
        apply_reset(2);
        repeat (400) rand_cycle(3, 20);

        ready_pct = 100;
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        @(negedge clk);
        checks++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL progress: consumed %0d instructions, required at least 200", consumed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
